// File: rtl/muldiv_pkg.sv
// Shared types and operation-decode helpers for the RV32M multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } muldiv_state_e;

    // MUL returns the low half, which is sign-agnostic, so it is treated as signed x signed
    function automatic logic is_signed_a(input muldiv_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_signed_b(input muldiv_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_div(input muldiv_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_rem(input muldiv_op_e op);
        return op inside {OP_REM, OP_REMU};
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response handshake bundle between the execute stage and the multiply/divide unit.
interface muldiv_if #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [OP_WIDTH-1:0]   Operation;
    logic [DATA_WIDTH-1:0] SrcA;
    logic [DATA_WIDTH-1:0] SrcB;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] Result;

    modport master (
        output in_valid, Operation, SrcA, SrcB, out_ready,
        input  in_ready, out_valid, Result
    );

    modport slave (
        input  in_valid, Operation, SrcA, SrcB, out_ready,
        output in_ready, out_valid, Result
    );
endinterface

// File: rtl/muldiv_core_step.sv
// One radix-2 iteration: shift-add multiply or restoring-divide trial subtract on {acc, lo}.
module muldiv_core_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  is_div,
    input  logic [DATA_WIDTH-1:0] acc,
    input  logic [DATA_WIDTH-1:0] lo,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] acc_nxt,
    output logic [DATA_WIDTH-1:0] lo_nxt
);

    logic [DATA_WIDTH:0] sum;
    logic [DATA_WIDTH:0] shifted;
    logic [DATA_WIDTH:0] diff;

    always_comb begin
        sum     = {1'b0, acc} + (lo[0] ? {1'b0, b} : '0);
        shifted = {acc, lo[DATA_WIDTH-1]};
        // acc < b always holds, so diff's top bit is a clean borrow flag
        diff    = shifted - {1'b0, b};
        if (is_div) begin
            acc_nxt = diff[DATA_WIDTH] ? shifted[DATA_WIDTH-1:0] : diff[DATA_WIDTH-1:0];
            lo_nxt  = {lo[DATA_WIDTH-2:0], ~diff[DATA_WIDTH]};
        end else begin
            acc_nxt = sum[DATA_WIDTH:1];
            lo_nxt  = {sum[0], lo[DATA_WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with valid/ready handshake and flush.
// Define MULDIV_FAST_MUL_EN for single-cycle multiplies; divides stay iterative.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 3,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     flush,
    muldiv_if.slave  bus
);

    localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    muldiv_state_e         state_q, state_d;
    muldiv_op_e            op_q, op_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0] lo_q, lo_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  neg_q, neg_d;
    logic                  rneg_q, rneg_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;

    muldiv_op_e            op_in;
    logic                  a_neg, b_neg;
    logic [DATA_WIDTH-1:0] a_abs, b_abs;
    logic                  div_zero, div_ovf;
    logic [DATA_WIDTH-1:0] special_res;

    logic [DATA_WIDTH-1:0]   acc_step, lo_step;
    logic [2*DATA_WIDTH-1:0] prod;
    logic [DATA_WIDTH-1:0]   quo, rem;
    logic [DATA_WIDTH-1:0]   final_res;

`ifdef MULDIV_FAST_MUL_EN
    logic signed [2*DATA_WIDTH+1:0] fa, fb, fp;
    logic [DATA_WIDTH-1:0]          fast_res;
`endif

    muldiv_core_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
        .is_div  (is_div(op_q)),
        .acc     (acc_q),
        .lo      (lo_q),
        .b       (b_q),
        .acc_nxt (acc_step),
        .lo_nxt  (lo_step)
    );

    // Operand decode: magnitudes and early-out cases
    always_comb begin
        op_in    = muldiv_op_e'(bus.Operation[2:0]);
        a_neg    = is_signed_a(op_in) & bus.SrcA[DATA_WIDTH-1];
        b_neg    = is_signed_b(op_in) & bus.SrcB[DATA_WIDTH-1];
        a_abs    = a_neg ? -bus.SrcA : bus.SrcA;
        b_abs    = b_neg ? -bus.SrcB : bus.SrcB;
        div_zero = is_div(op_in) && (bus.SrcB == '0);
        div_ovf  = (op_in == OP_DIV || op_in == OP_REM) &&
                   (bus.SrcA == MOST_NEG) && (bus.SrcB == '1);
        if (div_zero)
            special_res = is_rem(op_in) ? bus.SrcA : '1;
        else
            special_res = is_rem(op_in) ? '0 : bus.SrcA;
    end

`ifdef MULDIV_FAST_MUL_EN
    always_comb begin
        fa = {{(DATA_WIDTH+2){is_signed_a(op_in) & bus.SrcA[DATA_WIDTH-1]}}, bus.SrcA};
        fb = {{(DATA_WIDTH+2){is_signed_b(op_in) & bus.SrcB[DATA_WIDTH-1]}}, bus.SrcB};
        fp = fa * fb;
        fast_res = (op_in == OP_MUL) ? fp[DATA_WIDTH-1:0] : fp[2*DATA_WIDTH-1:DATA_WIDTH];
    end
`endif

    // Sign correction applied to the last iteration's output as it enters DONE
    always_comb begin
        prod = {acc_step, lo_step};
        if (neg_q)
            prod = -prod;
        quo = neg_q  ? -lo_step  : lo_step;
        rem = rneg_q ? -acc_step : acc_step;
        case (op_q)
            OP_MUL:                        final_res = prod[DATA_WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  final_res = prod[2*DATA_WIDTH-1:DATA_WIDTH];
            OP_DIV, OP_DIVU:               final_res = quo;
            default:                       final_res = rem;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        result_d = result_q;

        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.Result    = result_q;

        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_d   = op_in;
                        neg_d  = a_neg ^ b_neg;
                        rneg_d = a_neg;
                        acc_d  = '0;
                        lo_d   = a_abs;
                        b_d    = b_abs;
                        cnt_d  = CNT_WIDTH'(DATA_WIDTH);
                        if (div_zero || div_ovf) begin
                            result_d = special_res;
                            state_d  = DONE;
                        end
`ifdef MULDIV_FAST_MUL_EN
                        else if (!is_div(op_in)) begin
                            result_d = fast_res;
                            state_d  = DONE;
                        end
`endif
                        else begin
                            state_d = BUSY;
                        end
                    end
                end
                BUSY: begin
                    acc_d = acc_step;
                    lo_d  = lo_step;
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                    if (cnt_q == CNT_WIDTH'(1)) begin
                        result_d = final_res;
                        state_d  = DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready)
                        state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= OP_MUL;
            acc_q    <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (honours MULDIV_FAST_MUL_EN for multiply latency).
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int DW = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = DW + 1;
`endif
    localparam int DIV_LAT = DW + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int   errors = 0;
    int   checks = 0;

    muldiv_if #(.DATA_WIDTH(DW), .OP_WIDTH(3)) bus ();

    muldiv_unit #(.DATA_WIDTH(DW), .OP_WIDTH(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input muldiv_op_e op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        bus.in_valid  = 1'b1;
        bus.Operation = op;
        bus.SrcA      = a;
        bus.SrcB      = b;
    endtask

    // Counts edges from the accepting edge until out_valid appears
    task automatic await_result(input string tag, input logic [DW-1:0] exp, input int exp_lat);
        int lat = 0;
        do begin
            tick();
            lat++;
            bus.in_valid = 1'b0;
        end while (!bus.out_valid && lat < 100);
        check({tag, "_valid"}, DW'(bus.out_valid), DW'(1));
        check({tag, "_lat"}, DW'(lat), DW'(exp_lat));
        check({tag, "_res"}, bus.Result, exp);
    endtask

    task automatic take(input string tag);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, "_vld_clr"}, DW'(bus.out_valid), DW'(0));
        check({tag, "_rdy_set"}, DW'(bus.in_ready), DW'(1));
    endtask

    task automatic run(input string tag, input muldiv_op_e op, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic [DW-1:0] exp, input int exp_lat);
        issue(op, a, b);
        await_result(tag, exp, exp_lat);
        take(tag);
    endtask

    initial begin
        int seen;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.Operation = '0;
        bus.SrcA      = '0;
        bus.SrcB      = '0;

        tick();
        tick();
        check("rst_in_ready", DW'(bus.in_ready), DW'(1));
        check("rst_out_valid", DW'(bus.out_valid), DW'(0));
        check("rst_result", bus.Result, '0);
        rst_n = 1'b1;
        tick();

        run("mul_7xm3",   OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT);
        run("mul_6x7",    OP_MUL,    32'd6,        32'd7,        32'd42,       MUL_LAT);
        run("mulhu_max",  OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT);
        run("mulh_m1m1",  OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, MUL_LAT);
        run("mulh_minsq", OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT);
        run("div_m20_3",  OP_DIV,    32'hFFFFFFEC, 32'd3,        32'hFFFFFFFA, DIV_LAT);
        run("rem_m20_3",  OP_REM,    32'hFFFFFFEC, 32'd3,        32'hFFFFFFFE, DIV_LAT);
        run("div_20_m3",  OP_DIV,    32'd20,       32'hFFFFFFFD, 32'hFFFFFFFA, DIV_LAT);
        run("rem_20_m3",  OP_REM,    32'd20,       32'hFFFFFFFD, 32'd2,        DIV_LAT);
        run("divu_100_7", OP_DIVU,   32'd100,      32'd7,        32'd14,       DIV_LAT);
        run("remu_100_7", OP_REMU,   32'd100,      32'd7,        32'd2,        DIV_LAT);
        run("div_by0",    OP_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1);
        run("rem_by0",    OP_REM,    32'd5,        32'd0,        32'd5,        1);
        run("divu_by0",   OP_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1);
        run("remu_by0",   OP_REMU,   32'd9,        32'd0,        32'd9,        1);
        run("div_ovf",    OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run("rem_ovf",    OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

        // Backpressure: result must hold and new requests must be refused
        issue(OP_MUL, 32'd6, 32'd7);
        await_result("bp", 32'd42, MUL_LAT);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.SrcA     = 32'd99;
            tick();
            check("bp_hold_valid", DW'(bus.out_valid), DW'(1));
            check("bp_hold_res", bus.Result, 32'd42);
            check("bp_hold_rdy", DW'(bus.in_ready), DW'(0));
        end
        bus.in_valid = 1'b0;
        take("bp");

        // Flush in the tenth BUSY cycle
        issue(OP_DIVU, 32'd1000, 32'd3);
        tick();
        bus.in_valid = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_rdy", DW'(bus.in_ready), DW'(1));
        check("flush_vld", DW'(bus.out_valid), DW'(0));
        seen = 0;
        repeat (40) begin
            tick();
            if (bus.out_valid) seen++;
        end
        check("flush_noresult", DW'(seen), DW'(0));
        run("mulhsu_m1x2", OP_MULHSU, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, MUL_LAT);

        // Flush together with in_valid in IDLE must not accept
        issue(OP_DIV, 32'd5, 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        check("flushacc_rdy", DW'(bus.in_ready), DW'(1));
        check("flushacc_vld", DW'(bus.out_valid), DW'(0));

        // Reset mid-operation
        issue(OP_DIV, 32'hFFFFFFEC, 32'd3);
        tick();
        bus.in_valid = 1'b0;
        check("midrst_busy", DW'(bus.in_ready), DW'(0));
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_rdy", DW'(bus.in_ready), DW'(1));
        check("midrst_vld", DW'(bus.out_valid), DW'(0));
        check("midrst_res", bus.Result, '0);
        run("post_rst_divu", OP_DIVU, 32'd100, 32'd7, 32'd14, DIV_LAT);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
